i2s_sample_tx: RTL
==================

// Module: i2s_sample_tx
// PURPOSE
//  Sink end of the oscillator sample stream: accepts signed[16:0] samples through a valid/ready
//  handshake and serialises them to the stereo audio DAC as standard I2S (Philips) frames.
//  Sits between the oscillator/mixer output and the board DAC pins; mono input, duplicated L=R.
//  Generates bclk/lrclk from the system clock, with one sample consumed per frame.
// PARAMETERS
//  BCLK_DIV  4  sys clk cycles per bclk half-period (>=2); bclk period = 2*BCLK_DIV clk
//  SLOT_BITS 16 bits per channel slot; frame = 2*SLOT_BITS bclk periods
// PORTS
//  clk          in  1   system clock, single clock domain
//  rst          in  1   reset: one clock; reset is asynchronous and active-low
//  en           in  1   transmitter enable
//  sample       in  17  signed audio sample (same format as oscillator output)
//  sampleValid  in  1   sample is valid this cycle
//  sampleReady  out 1   holding register empty; transfer when sampleValid & sampleReady
//  bclk         out 1   I2S bit clock
//  lrclk        out 1   I2S word select, 0 = left, 1 = right
//  sdata        out 1   I2S serial data, MSB first, changes on bclk falling edge
//  underrun     out 1   one-clk pulse: frame started with no sample available
// BEHAVIOUR
//  Reset (rst=0, asynchronous): bclk=0, lrclk=0, sdata=0, underrun=0, divider=0,
//   bit counter k=31, holding register empty (sampleReady=1), frame register=0.
//  en=0: divider held at 0, k held at 31; bclk/lrclk/sdata driven 0. The holding register and
//   handshake keep working, so one sample can be preloaded. Deasserting en mid-frame stops
//   output on the next clk; the partial frame is discarded. Re-enable starts a fresh frame.
//  Divider: counts 0..BCLK_DIV-1 while en=1. At terminal count bclk toggles.
//   A 1->0 toggle is a "fall event". All lrclk/sdata/k/frame updates occur on the clk edge that
//   drives bclk low, so the DAC sees data stable for the whole high phase.
//  On each fall event: k <= (k+1) mod 32; lrclk <= new k[4]; sdata <= F[15-((k_new-1) mod 16)],
//   where F is the frame register. This gives the I2S one-bit delay: left MSB at k=1, left LSB
//   at k=16, right MSB at k=17, right LSB at k=0 of the next frame.
//  Frame load, on the fall event where k becomes 1, before sdata is selected:
//   - holding register full: F <= sat16(hold); holding register emptied.
//   - holding register empty: F <= 0 (silence); underrun=1 for exactly that clk.
//  sat16: clamp the 17-bit signed value to [-32768, 32767].
//   Values >32767 -> 16'h7FFF; values < -32768 -> 16'h8000; otherwise take the low 16 bits.
//  Handshake: sampleReady is a flop output equal to "holding register empty".
//   - Transfer (valid & ready) fills the holding register; ready drops the next cycle.
//   - A transfer in the same clk as a frame load is accepted; the register stays full with
//     the new sample.
//   - sample/sampleValid are ignored while ready=0; no combinational valid->ready path.
//  Throughput: at most one sample per 32*2*BCLK_DIV clk. Sources must buffer or stall.
// TESTING
//  (BCLK_DIV=2, so one frame = 128 clk)
//  1. rst low for 3 clk with no clock edges -> all outputs 0 immediately; after release,
//     sampleReady=1 and bclk stays 0 while en=0.
//  2. Preload 17'sh01234, then en=1 -> frame 1: lrclk low for k=0..15;
//     sdata bits 0x1234 MSB-first from k=1 (left) and from k=17 (right); underrun stays 0.
//  3. Push 17'sh0FFFF -> 16'h7FFF on sdata; push 17'sh10000 (-65536) -> 16'h8000;
//     push 17'sh1FFFF (-1) -> 16'hFFFF.
//  4. Never send a sample -> every frame's sdata is all 0; underrun pulses for 1 clk
//     once per 128 clk, aligned to the k=1 fall event.
//  5. Hold sampleValid=1 continuously with an incrementing sample -> exactly one transfer
//     per 128 clk; ready low between transfers; each frame carries the next value.
//  6. Assert rst low mid-frame at k=9, then release -> outputs 0 asynchronously;
//     after release with en=1, a clean frame starts from k=0 with F=0.
//     Also: drop en at k=20 -> bclk/lrclk/sdata are 0 the next clk.

Source files
------------

// File: rtl/i2s_sample_tx_if.sv
// Sample handshake between the oscillator/mixer stream and the I2S transmitter.
interface i2s_sample_tx_if;
    logic signed [16:0] sample;
    logic               sampleValid;
    logic               sampleReady;

    modport master (output sample, output sampleValid, input sampleReady);
    modport slave  (input sample, input sampleValid, output sampleReady);
endinterface

// File: rtl/i2s_sample_tx.sv
// Purpose: serialise mono 17-bit samples as saturated 16-bit I2S (Philips) frames, L=R.
// Latency: a held sample is loaded at the next frame start (k=1 fall event), then sent MSB first.
// Backpressure: one-entry holding register; sampleReady is registered and means "empty".
module i2s_sample_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    i2s_sample_tx_if.slave  s_if,
    output logic            bclk,
    output logic            lrclk,
    output logic            sdata,
    output logic            underrun
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int KW = $clog2(2 * SLOT_BITS);
    localparam int PW = KW - 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0]        r_div;
    logic [KW-1:0]        r_k;
    logic                 r_bclk;
    logic                 r_lrclk;
    logic                 r_sdata;
    logic                 r_underrun;
    logic                 r_ready;
    logic signed [16:0]   r_hold;
    logic [15:0]          r_frame;

    logic                 w_term;
    logic                 w_fall;
    logic                 w_load;
    logic                 w_xfer;
    logic [KW-1:0]        w_k_next;
    logic [15:0]          w_frame_next;
    logic [SLOT_BITS-1:0] w_slot;
    logic [PW-1:0]        w_pos;
    logic                 w_sd;

    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (!v[16] && v[15]) begin
            return 16'h7FFF;
        end else if (v[16] && !v[15]) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Bit position within the slot is (k_new-1), which is simply the old k.
    always_comb begin
        w_term       = (r_div == DIV_LAST);
        w_fall       = en && w_term && r_bclk;
        w_k_next     = r_k + 1'b1;
        w_load       = w_fall && (w_k_next == KW'(1));
        w_xfer       = s_if.sampleValid && r_ready;
        w_frame_next = r_frame;
        if (w_load) begin
            w_frame_next = r_ready ? 16'h0000 : sat16(r_hold);
        end
        w_slot = SLOT_BITS'(w_frame_next) << (SLOT_BITS - 16);
        w_pos  = r_k[PW-1:0];
        w_sd   = w_slot[~w_pos];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_k        <= '1;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_ready    <= 1'b1;
            r_hold     <= '0;
            r_frame    <= '0;
        end else begin
            r_underrun <= w_load && r_ready;

            // A new transfer wins over the load's emptying, so the register stays full.
            if (w_xfer) begin
                r_hold  <= s_if.sample;
                r_ready <= 1'b0;
            end else if (w_load && !r_ready) begin
                r_ready <= 1'b1;
            end

            if (!en) begin
                r_div   <= '0;
                r_k     <= '1;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                r_sdata <= 1'b0;
                r_frame <= '0;
            end else begin
                if (w_term) begin
                    r_div  <= '0;
                    r_bclk <= ~r_bclk;
                end else begin
                    r_div <= r_div + 1'b1;
                end
                if (w_fall) begin
                    r_k     <= w_k_next;
                    r_lrclk <= w_k_next[KW-1];
                    r_sdata <= w_sd;
                    r_frame <= w_frame_next;
                end
            end
        end
    end

    assign s_if.sampleReady = r_ready;
    assign bclk             = r_bclk;
    assign lrclk            = r_lrclk;
    assign sdata            = r_sdata;
    assign underrun         = r_underrun;
endmodule
